envm_fault_map: RTL and testbench
=================================

# envm_fault_map

Parametrised fault-map store for the systolic-array self-test flow. It captures per-row PE detection results plus row/column fault flags from the detection phase. On command it compacts the faulty rows into a bounded entry table that the repair logic consumes. It also streams the full map out serially for off-chip readback. It sits between the BIST detection logic and the row/column repair (remapping) logic.

## Interface
- SYSTOLIC_SIZE, 8, array dimension N (rows = columns = N)
- FAULTY_STORAGE_DEPTH, 8, number of compacted faulty-row entries D
- ADDR_WIDTH, $clog2(SYSTOLIC_SIZE), row index width
- CNT_WIDTH, $clog2(FAULTY_STORAGE_DEPTH+1), width of fault_count
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- detection_en  in  1  write strobe for one detection row
- count  in  ADDR_WIDTH  row index being written
- pe_detection  in  N  faulty-PE pattern of row `count`, bit c = PE (count,c)
- row_fault_detection  in  1  row-fault flag for index `count`
- column_fault_detection  in  1  column-fault flag for index `count`
- build_start  in  1  pulse: start compaction
- scan_start  in  1  pulse: start serial readback
- build_busy  out  1  compaction in progress
- build_done  out  1  one-cycle pulse, compaction finished
- envm_faulty_patterns_flat  out  D*N  entry e pattern at [e*N +: N]
- envm_faulty_row_addrs_flat  out  D*ADDR_WIDTH  entry e row at [e*ADDR_WIDTH +: ADDR_WIDTH]
- envm_faulty_valid_mask  out  D  bit e = entry e valid
- faulty_row_map  out  N  stored row-fault flags
- faulty_column_map  out  N  stored column-fault flags
- fault_count  out  CNT_WIDTH  number of valid entries
- fault_overflow  out  1  more faulty rows than D were found
- scan_out  out  1  serial data
- scan_valid  out  1  scan_out is valid
- scan_last  out  1  final bit of frame

## Operation
- FSM states: IDLE, BUILD, SCAN. Reset to IDLE.
- Detection write: accepted only in IDLE with detection_en=1 and count<N. It writes pe_storage[count]=pe_detection, faulty_row_map[count]=row_fault_detection and faulty_column_map[count]=column_fault_detection. Writes are ignored in BUILD/SCAN or when count>=N.
- IDLE, build_start=1 -> BUILD:
  - Clears valid mask, patterns, addrs, fault_count and fault_overflow.
  - Sets row pointer r=0.
  - build_start has priority over scan_start; scan_start in the same cycle is dropped.
- BUILD: one row per cycle, r=0..N-1 ascending.
  - If pe_storage[r]!=0 and fault_count<D: entry[fault_count]={pattern, r}, valid set, fault_count+1.
  - If pe_storage[r]!=0 and fault_count==D: fault_overflow=1; the row is discarded.
  - After r=N-1: -> IDLE, build_done=1 for one cycle.
  - Zero patterns produce no entry, even if the row/column flag is set.
- IDLE, scan_start=1 -> SCAN. The frame is sent LSB first, in this order:
  - faulty_row_map (N bits)
  - faulty_column_map (N bits)
  - for e=0..D-1: valid[e], row addr (ADDR_WIDTH bits), pattern (N bits)
- Frame length L = 2N + D*(1+ADDR_WIDTH+N); the default is 112. After the last bit the FSM returns to IDLE.
- Start pulses while not IDLE are ignored.
- Reset (any state): all storage, maps, entries, counters and flags are cleared; FSM -> IDLE. Reset mid-BUILD or mid-SCAN aborts with no done/last pulse.

## Timing
- Reset values: every output is 0.
- Detection write lands on the edge sampling detection_en. A write in the same cycle as build_start is visible to BUILD (row 0 is read on the next edge).
- build_start sampled on edge E0:
  - build_busy is high from E0+1 through edge E0+N.
  - Row r is processed on edge E0+1+r.
  - build_done is high in the cycle after edge E0+N, with build_busy low.
  - Entry outputs are final when build_done is high.
- build_start can be accepted again in the build_done cycle.
- scan_start sampled on edge S0:
  - Bit k is presented in the cycle after edge S0+k (k=0..L-1) with scan_valid=1.
  - scan_last=1 with bit L-1.
  - scan_valid drops the following cycle.
- Outputs are registered; entry outputs are stable outside BUILD.

## Test plan
- Reset: drive rst_n=0 with random stored data -> all outputs 0, FSM IDLE, fault_count=0.
- Basic build: write rows 2 and 5 with patterns 0x10 and 0x81, other rows 0, then build_start:
  - build_busy high for 8 cycles; build_done pulse.
  - valid=0x03, entry0={0x10,2}, entry1={0x81,5}, fault_count=2.
- Overflow: D=8, all 8 rows nonzero, build -> valid=0xFF, fault_count=8, overflow=0. Rebuild with D=4 -> valid=0x0F, entries hold rows 0-3, overflow=1.
- Scan: row map 0x21, column map 0x04, one entry {0x10,2}, scan_start -> 112 valid bits in the specified order; scan_last on bit 111.
- Guards:
  - detection_en during BUILD leaves storage unchanged.
  - build_start and scan_start in the same cycle -> BUILD only.
  - count>=N write ignored (N=6).
- Reset mid-BUILD at row 3 -> no build_done, outputs cleared; a subsequent build completes normally.

Source files
------------

// File: rtl/envm_fault_map.sv
// Fault-map store for the systolic-array self-test flow. Captures per-row detection results,
// compacts faulty rows into a bounded entry table and streams the whole map out serially.
module envm_fault_map #(
  parameter int unsigned SYSTOLIC_SIZE        = 8,
  parameter int unsigned FAULTY_STORAGE_DEPTH = 8,
  parameter int unsigned ADDR_WIDTH           = $clog2(SYSTOLIC_SIZE),
  parameter int unsigned CNT_WIDTH            = $clog2(FAULTY_STORAGE_DEPTH + 1)
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         detection_en,
  input  logic [ADDR_WIDTH-1:0]                        count,
  input  logic [SYSTOLIC_SIZE-1:0]                     pe_detection,
  input  logic                                         row_fault_detection,
  input  logic                                         column_fault_detection,
  input  logic                                         build_start,
  input  logic                                         scan_start,
  output logic                                         build_busy,
  output logic                                         build_done,
  output logic [FAULTY_STORAGE_DEPTH*SYSTOLIC_SIZE-1:0] envm_faulty_patterns_flat,
  output logic [FAULTY_STORAGE_DEPTH*ADDR_WIDTH-1:0]   envm_faulty_row_addrs_flat,
  output logic [FAULTY_STORAGE_DEPTH-1:0]              envm_faulty_valid_mask,
  output logic [SYSTOLIC_SIZE-1:0]                     faulty_row_map,
  output logic [SYSTOLIC_SIZE-1:0]                     faulty_column_map,
  output logic [CNT_WIDTH-1:0]                         fault_count,
  output logic                                         fault_overflow,
  output logic                                         scan_out,
  output logic                                         scan_valid,
  output logic                                         scan_last
);

  localparam int unsigned N        = SYSTOLIC_SIZE;
  localparam int unsigned D        = FAULTY_STORAGE_DEPTH;
  localparam int unsigned EntryW   = 1 + ADDR_WIDTH + N;
  localparam int unsigned FrameLen = 2 * N + D * EntryW;
  localparam int unsigned IdxW     = $clog2(FrameLen);
  localparam int unsigned EntW     = (D > 1) ? $clog2(D) : 1;

  typedef enum logic [1:0] {StIdle, StBuild, StScan} state_e;

  state_e                              state_q, state_d;
  logic [N-1:0][N-1:0]                 pe_q, pe_d;
  logic [N-1:0]                        row_map_q, row_map_d;
  logic [N-1:0]                        col_map_q, col_map_d;
  logic [D-1:0][N-1:0]                 pat_q, pat_d;
  logic [D-1:0][ADDR_WIDTH-1:0]        addr_q, addr_d;
  logic [D-1:0]                        valid_q, valid_d;
  logic [CNT_WIDTH-1:0]                cnt_q, cnt_d;
  logic                                ovf_q, ovf_d;
  logic [ADDR_WIDTH-1:0]               row_q, row_d;
  logic                                done_q, done_d;
  logic [IdxW-1:0]                     scan_idx_q, scan_idx_d;
  logic                                scan_out_q, scan_out_d;
  logic                                scan_valid_q, scan_valid_d;
  logic                                scan_last_q, scan_last_d;
  logic [FrameLen-1:0]                 frame;
  logic [EntW-1:0]                     ent_idx;

  // Readback frame: row map, column map, then {valid, addr, pattern} per entry, LSB first.
  always_comb begin
    frame          = '0;
    frame[N-1:0]   = row_map_q;
    frame[2*N-1:N] = col_map_q;
    for (int e = 0; e < D; e++) begin
      frame[2*N + e*EntryW]                       = valid_q[e];
      frame[2*N + e*EntryW + 1 +: ADDR_WIDTH]     = addr_q[e];
      frame[2*N + e*EntryW + 1 + ADDR_WIDTH +: N] = pat_q[e];
    end
  end

  // Next-state: detection capture, row-by-row compaction and serial readback.
  always_comb begin
    state_d      = state_q;
    pe_d         = pe_q;
    row_map_d    = row_map_q;
    col_map_d    = col_map_q;
    pat_d        = pat_q;
    addr_d       = addr_q;
    valid_d      = valid_q;
    cnt_d        = cnt_q;
    ovf_d        = ovf_q;
    row_d        = row_q;
    done_d       = 1'b0;
    scan_idx_d   = scan_idx_q;
    scan_out_d   = 1'b0;
    scan_valid_d = 1'b0;
    scan_last_d  = 1'b0;
    ent_idx      = EntW'(cnt_q);
    unique case (state_q)
      StIdle: begin
        if (detection_en && (32'(count) < N)) begin
          pe_d[count]      = pe_detection;
          row_map_d[count] = row_fault_detection;
          col_map_d[count] = column_fault_detection;
        end
        // build_start wins; a simultaneous scan_start is dropped.
        if (build_start) begin
          valid_d = '0;
          pat_d   = '0;
          addr_d  = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          row_d   = '0;
          state_d = StBuild;
        end else if (scan_start) begin
          scan_out_d   = frame[0];
          scan_valid_d = 1'b1;
          scan_last_d  = (FrameLen == 1);
          scan_idx_d   = IdxW'(1);
          state_d      = StScan;
        end
      end
      StBuild: begin
        if (pe_q[row_q] != '0) begin
          if (cnt_q < CNT_WIDTH'(D)) begin
            pat_d[ent_idx]   = pe_q[row_q];
            addr_d[ent_idx]  = row_q;
            valid_d[ent_idx] = 1'b1;
            cnt_d            = cnt_q + CNT_WIDTH'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
        if (row_q == ADDR_WIDTH'(N - 1)) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          row_d = row_q + ADDR_WIDTH'(1);
        end
      end
      StScan: begin
        // The last bit has just been presented; leave with scan_valid dropping.
        if (scan_last_q) begin
          state_d = StIdle;
        end else begin
          scan_out_d   = frame[scan_idx_q];
          scan_valid_d = 1'b1;
          scan_last_d  = (scan_idx_q == IdxW'(FrameLen - 1));
          scan_idx_d   = scan_idx_q + IdxW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      pe_q         <= '0;
      row_map_q    <= '0;
      col_map_q    <= '0;
      pat_q        <= '0;
      addr_q       <= '0;
      valid_q      <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      row_q        <= '0;
      done_q       <= 1'b0;
      scan_idx_q   <= '0;
      scan_out_q   <= 1'b0;
      scan_valid_q <= 1'b0;
      scan_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pe_q         <= pe_d;
      row_map_q    <= row_map_d;
      col_map_q    <= col_map_d;
      pat_q        <= pat_d;
      addr_q       <= addr_d;
      valid_q      <= valid_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      row_q        <= row_d;
      done_q       <= done_d;
      scan_idx_q   <= scan_idx_d;
      scan_out_q   <= scan_out_d;
      scan_valid_q <= scan_valid_d;
      scan_last_q  <= scan_last_d;
    end
  end

  assign build_busy                 = (state_q == StBuild);
  assign build_done                 = done_q;
  assign envm_faulty_patterns_flat  = pat_q;
  assign envm_faulty_row_addrs_flat = addr_q;
  assign envm_faulty_valid_mask     = valid_q;
  assign faulty_row_map             = row_map_q;
  assign faulty_column_map          = col_map_q;
  assign fault_count                = cnt_q;
  assign fault_overflow             = ovf_q;
  assign scan_out                   = scan_out_q;
  assign scan_valid                 = scan_valid_q;
  assign scan_last                  = scan_last_q;

endmodule

// File: tb/tb_envm_fault_map.sv
// Bench for envm_fault_map: default 8x8 instance plus a 6-row, 4-entry instance.
module tb_envm_fault_map;

  typedef struct packed {
    logic [7:0]  vm;
    logic [3:0]  fc;
    logic        ovf;
    logic [63:0] pats;
    logic [23:0] addrs;
  } bexp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: N=8, D=8.
  logic       e0 = 0, rf0 = 0, cf0 = 0, bs0 = 0, ss0 = 0;
  logic [2:0] c0 = '0;
  logic [7:0] p0 = '0;
  logic        busy0, done0, ovf0, so0, sv0, sl0;
  logic [63:0] pats0;
  logic [23:0] addrs0;
  logic [7:0]  vm0, rmap0, cmap0;
  logic [3:0]  fc0;

  // Instance 1: N=6, D=4.
  logic       e1 = 0, rf1 = 0, cf1 = 0, bs1 = 0, ss1 = 0;
  logic [2:0] c1 = '0;
  logic [5:0] p1 = '0;
  logic        busy1, done1, ovf1, so1, sv1, sl1;
  logic [23:0] pats1;
  logic [11:0] addrs1;
  logic [3:0]  vm1;
  logic [5:0]  rmap1, cmap1;
  logic [2:0]  fc1;

  envm_fault_map u0 (
    .clk(clk), .rst_n(rst_n), .detection_en(e0), .count(c0), .pe_detection(p0),
    .row_fault_detection(rf0), .column_fault_detection(cf0), .build_start(bs0),
    .scan_start(ss0), .build_busy(busy0), .build_done(done0),
    .envm_faulty_patterns_flat(pats0), .envm_faulty_row_addrs_flat(addrs0),
    .envm_faulty_valid_mask(vm0), .faulty_row_map(rmap0), .faulty_column_map(cmap0),
    .fault_count(fc0), .fault_overflow(ovf0), .scan_out(so0), .scan_valid(sv0),
    .scan_last(sl0)
  );

  envm_fault_map #(.SYSTOLIC_SIZE(6), .FAULTY_STORAGE_DEPTH(4)) u1 (
    .clk(clk), .rst_n(rst_n), .detection_en(e1), .count(c1), .pe_detection(p1),
    .row_fault_detection(rf1), .column_fault_detection(cf1), .build_start(bs1),
    .scan_start(ss1), .build_busy(busy1), .build_done(done1),
    .envm_faulty_patterns_flat(pats1), .envm_faulty_row_addrs_flat(addrs1),
    .envm_faulty_valid_mask(vm1), .faulty_row_map(rmap1), .faulty_column_map(cmap1),
    .fault_count(fc1), .fault_overflow(ovf1), .scan_out(so1), .scan_valid(sv1),
    .scan_last(sl1)
  );

  int sel = 0;
  int total = 0;
  int bad = 0;
  int nn[2] = '{8, 6};
  int dd[2] = '{8, 4};

  // Reference model state.
  logic [7:0] m_pe[2][8];
  logic [7:0] m_row[2];
  logic [7:0] m_col[2];
  bexp_t      m_ent[2];

  bexp_t bq[$];
  logic  bit_q[$];

  // Selected-instance view, patterns widened to 8-bit stride.
  logic        o_busy, o_done, o_ovf, o_so, o_sv, o_sl;
  logic [7:0]  o_vm, o_rmap, o_cmap;
  logic [3:0]  o_fc;
  logic [63:0] o_pats;
  logic [23:0] o_addrs;
  always_comb begin
    o_pats  = '0;
    o_addrs = '0;
    if (sel == 0) begin
      o_busy = busy0; o_done = done0; o_ovf = ovf0; o_so = so0; o_sv = sv0; o_sl = sl0;
      o_vm = vm0; o_rmap = rmap0; o_cmap = cmap0; o_fc = fc0;
      o_pats = pats0; o_addrs = addrs0;
    end else begin
      o_busy = busy1; o_done = done1; o_ovf = ovf1; o_so = so1; o_sv = sv1; o_sl = sl1;
      o_vm = {4'b0, vm1}; o_rmap = {2'b0, rmap1}; o_cmap = {2'b0, cmap1}; o_fc = {1'b0, fc1};
      for (int e = 0; e < 4; e++) begin
        o_pats[e*8 +: 8]  = {2'b0, pats1[e*6 +: 6]};
        o_addrs[e*3 +: 3] = addrs1[e*3 +: 3];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic en, input logic [2:0] cnt, input logic [7:0] pe,
                        input logic rf, input logic cf, input logic bs, input logic ss);
    if (sel == 0) begin
      e0 = en; c0 = cnt; p0 = pe; rf0 = rf; cf0 = cf; bs0 = bs; ss0 = ss;
    end else begin
      e1 = en; c1 = cnt; p1 = pe[5:0]; rf1 = rf; cf1 = cf; bs1 = bs; ss1 = ss;
    end
  endtask

  task automatic clear_model();
    for (int u = 0; u < 2; u++) begin
      for (int r = 0; r < 8; r++) m_pe[u][r] = '0;
      m_row[u] = '0;
      m_col[u] = '0;
      m_ent[u] = '0;
    end
  endtask

  task automatic wr(input int row, input logic [7:0] pe, input logic rf, input logic cf);
    @(negedge clk);
    set_in(1'b1, 3'(row), pe, rf, cf, 1'b0, 1'b0);
    if (row < nn[sel]) begin
      m_pe[sel][row]  = pe & 8'((1 << nn[sel]) - 1);
      m_row[sel][row] = rf;
      m_col[sel][row] = cf;
    end
    @(negedge clk);
    set_in(1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic bexp_t model_build(input int u);
    bexp_t x = '0;
    int    n = 0;
    for (int r = 0; r < nn[u]; r++) begin
      if (m_pe[u][r] != 8'd0) begin
        if (n < dd[u]) begin
          x.pats[n*8 +: 8]  = m_pe[u][r];
          x.addrs[n*3 +: 3] = 3'(r);
          x.vm[n]           = 1'b1;
          n++;
        end else begin
          x.ovf = 1'b1;
        end
      end
    end
    x.fc = 4'(n);
    return x;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 64'(o_busy), 64'd0);
    chk({tag, "_done"}, 64'(o_done), 64'd0);
    chk({tag, "_valid"}, 64'(o_vm), 64'd0);
    chk({tag, "_count"}, 64'(o_fc), 64'd0);
    chk({tag, "_ovf"}, 64'(o_ovf), 64'd0);
    chk({tag, "_rmap"}, 64'(o_rmap), 64'd0);
    chk({tag, "_cmap"}, 64'(o_cmap), 64'd0);
    chk({tag, "_pats"}, o_pats, 64'd0);
    chk({tag, "_addrs"}, 64'(o_addrs), 64'd0);
    chk({tag, "_scan"}, 64'({o_so, o_sv, o_sl}), 64'd0);
  endtask

  // Build with optional detection write during BUILD and simultaneous scan_start.
  task automatic do_build(input bit poke, input bit both);
    int    busy_n = 0;
    bit    got_done = 0;
    bit    saw_scan = 0;
    bexp_t x;
    bq.push_back(model_build(sel));
    @(negedge clk);
    set_in(1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b1, both);
    @(negedge clk);
    set_in(poke, 3'd1, 8'hFF, poke, poke, 1'b0, 1'b0);
    for (int i = 0; i < 40 && !got_done; i++) begin
      if (o_sv) saw_scan = 1;
      if (o_busy) busy_n++;
      else if (o_done) got_done = 1;
      if (!got_done) begin
        @(negedge clk);
        set_in(1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
    end
    chk("build_done", 64'(got_done), 64'd1);
    chk("busy_cycles", 64'(busy_n), 64'(nn[sel]));
    if (both) chk("no_scan_in_build", 64'(saw_scan), 64'd0);
    x = bq.pop_front();
    chk("valid_mask", 64'(o_vm), 64'(x.vm));
    chk("fault_count", 64'(o_fc), 64'(x.fc));
    chk("overflow", 64'(o_ovf), 64'(x.ovf));
    for (int e = 0; e < dd[sel]; e++) begin
      chk("entry_pat", 64'(o_pats[e*8 +: 8]), 64'(x.pats[e*8 +: 8]));
      chk("entry_addr", 64'(o_addrs[e*3 +: 3]), 64'(x.addrs[e*3 +: 3]));
    end
    chk("row_map", 64'(o_rmap), 64'(m_row[sel]));
    chk("col_map", 64'(o_cmap), 64'(m_col[sel]));
    m_ent[sel] = x;
    @(negedge clk);
    chk("done_pulse_end", 64'({o_done, o_busy}), 64'd0);
  endtask

  task automatic do_scan();
    int    n = nn[sel];
    int    len;
    bexp_t x = m_ent[sel];
    logic  b;
    for (int r = 0; r < n; r++) bit_q.push_back(m_row[sel][r]);
    for (int r = 0; r < n; r++) bit_q.push_back(m_col[sel][r]);
    for (int e = 0; e < dd[sel]; e++) begin
      bit_q.push_back(x.vm[e]);
      for (int k = 0; k < 3; k++) bit_q.push_back(x.addrs[e*3 + k]);
      for (int k = 0; k < n; k++) bit_q.push_back(x.pats[e*8 + k]);
    end
    len = bit_q.size();
    chk("frame_len", 64'(len), 64'(2 * n + dd[sel] * (4 + n)));
    @(negedge clk);
    set_in(1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    set_in(1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < len; k++) begin
      b = bit_q.pop_front();
      chk("scan_valid", 64'(o_sv), 64'd1);
      chk("scan_bit", 64'(o_so), 64'(b));
      chk("scan_last", 64'(o_sl), 64'(k == len - 1));
      @(negedge clk);
    end
    chk("scan_end", 64'({o_sv, o_sl}), 64'd0);
  endtask

  initial begin
    clear_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sel = 0; chk_zero("init0");
    sel = 1; chk_zero("init1");

    // Reset with random stored data.
    sel = 0;
    for (int r = 0; r < 8; r++) wr(r, 8'($urandom_range(1, 255)), 1'($urandom), 1'($urandom));
    do_build(1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    clear_model();
    chk_zero("reset");
    rst_n = 1'b1;

    // Basic build; detection write during BUILD and simultaneous scan_start must be ignored.
    wr(2, 8'h10, 1'b0, 1'b0);
    wr(5, 8'h81, 1'b0, 1'b0);
    do_build(1'b1, 1'b1);
    chk("basic_valid", 64'(o_vm), 64'h03);
    chk("basic_e1", 64'({o_pats[15:8], o_addrs[5:3]}), 64'({8'h81, 3'd5}));

    // Scan frame: row map 0x21, column map 0x04, one entry {0x10, 2}.
    wr(0, 8'h00, 1'b1, 1'b0);
    wr(2, 8'h10, 1'b0, 1'b1);
    wr(5, 8'h00, 1'b1, 1'b0);
    do_build(1'b0, 1'b0);
    chk("scan_setup", 64'({o_rmap, o_cmap, o_vm}), 64'({8'h21, 8'h04, 8'h01}));
    do_scan();

    // Full table, no overflow.
    for (int r = 0; r < 8; r++) wr(r, 8'(r * 16 + 1), 1'b0, 1'b0);
    do_build(1'b0, 1'b0);
    chk("full_valid", 64'({o_vm, o_fc, o_ovf}), 64'({8'hFF, 4'd8, 1'b0}));

    // Reset while row 3 is being processed aborts the build.
    @(negedge clk);
    set_in(1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    set_in(1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    clear_model();
    chk_zero("mid_build_reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("no_done_after_abort", 64'(o_done), 64'd0);
    wr(1, 8'h3C, 1'b1, 1'b0);
    wr(7, 8'h80, 1'b0, 1'b1);
    do_build(1'b0, 1'b0);

    // Small instance: out-of-range writes ignored, overflow with D=4.
    sel = 1;
    wr(6, 8'hFF, 1'b1, 1'b1);
    wr(7, 8'hFF, 1'b1, 1'b1);
    @(negedge clk);
    chk("oob_maps", 64'({o_rmap, o_cmap}), 64'd0);
    for (int r = 0; r < 6; r++) wr(r, 8'(r + 1), 1'(r & 1), 1'b0);
    do_build(1'b0, 1'b0);
    chk("ovf_small", 64'({o_vm, o_fc, o_ovf}), 64'({8'h0F, 4'd4, 1'b1}));
    do_scan();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
